bram_sp_stream: RTL and testbench

- Parametrised successor to the team's single-port block RAM: adds byte-write enables, a valid/ready request port and a valid/ready response port with a credit-limited output FIFO.
- Read data is never lost under consumer backpressure.
- Sits between codec pipeline stages (line buffers, coefficient stores) that stall independently of the RAM.

---
 rtl/bram_sp_stream_if.sv | 43 ++++
 rtl/bram_sp_stream.sv | 180 ++++++++++++++++++
 tb/tb_bram_sp_stream.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_sp_stream_if.sv
// Request/response stream bundle for bram_sp_stream.
// rsp_perr and perr_inject exist only when BRAM_SP_STREAM_PARITY_EN is defined.
interface bram_sp_stream_if #(
  parameter int NB_COL    = 4,
  parameter int COL_WIDTH = 8,
  parameter int RAM_DEPTH = 1024
);
  localparam int RAM_WIDTH = NB_COL * COL_WIDTH;
  localparam int AW        = $clog2(RAM_DEPTH);

  logic                 req_valid;
  logic                 req_ready;
  logic [AW-1:0]        req_addr;
  logic                 req_we;
  logic [NB_COL-1:0]    req_be;
  logic [RAM_WIDTH-1:0] req_data;
  logic                 req_rsp;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [RAM_WIDTH-1:0] rsp_data;
`ifdef BRAM_SP_STREAM_PARITY_EN
  logic [NB_COL-1:0]    rsp_perr;
  logic                 perr_inject;
`endif

  modport master (
    output req_valid, req_addr, req_we, req_be, req_data, req_rsp, rsp_ready,
`ifdef BRAM_SP_STREAM_PARITY_EN
    output perr_inject,
    input  rsp_perr,
`endif
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_be, req_data, req_rsp, rsp_ready,
`ifdef BRAM_SP_STREAM_PARITY_EN
    input  perr_inject,
    output rsp_perr,
`endif
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/bram_sp_stream.sv
// Single-port byte-write block RAM behind valid/ready request and response streams,
// with a credit-limited response FIFO. Optional per-column parity: BRAM_SP_STREAM_PARITY_EN.
module bram_sp_stream #(
  parameter int    NB_COL     = 4,
  parameter int    COL_WIDTH  = 8,
  parameter int    RAM_DEPTH  = 1024,
  parameter int    LATENCY    = 2,
  parameter string WRITE_MODE = "READ_FIRST",
  parameter string INIT_FILE  = ""
) (
  input logic             clka,
  input logic             rsta,
  bram_sp_stream_if.slave bus
);
  localparam int RAM_WIDTH   = NB_COL * COL_WIDTH;
  localparam int AW          = $clog2(RAM_DEPTH);
  localparam bit WRITE_FIRST = (WRITE_MODE == "WRITE_FIRST");
  localparam int F           = LATENCY + 1;
  localparam int CW          = $clog2(F + 1);
  localparam int PTW         = $clog2(F);
`ifdef BRAM_SP_STREAM_PARITY_EN
  localparam int PLW         = RAM_WIDTH + NB_COL;
`else
  localparam int PLW         = RAM_WIDTH;
`endif
  localparam logic [CW-1:0]  F_C      = CW'(F);
  localparam logic [PTW-1:0] LAST_PTR = PTW'(F - 1);

  function automatic logic [RAM_WIDTH-1:0] merge_word(input logic [RAM_WIDTH-1:0] old_word,
                                                      input logic [RAM_WIDTH-1:0] new_word,
                                                      input logic [NB_COL-1:0]    be);
    logic [RAM_WIDTH-1:0] w;
    w = old_word;
    for (int c = 0; c < NB_COL; c++)
      if (be[c]) w[c*COL_WIDTH +: COL_WIDTH] = new_word[c*COL_WIDTH +: COL_WIDTH];
    return w;
  endfunction

  function automatic logic [PTW-1:0] ptr_inc(input logic [PTW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

`ifdef BRAM_SP_STREAM_PARITY_EN
  function automatic logic [NB_COL-1:0] col_parity(input logic [RAM_WIDTH-1:0] w);
    logic [NB_COL-1:0] p;
    for (int c = 0; c < NB_COL; c++) p[c] = ^w[c*COL_WIDTH +: COL_WIDTH];
    return p;
  endfunction
`endif

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] cur_word, wr_word, ret_word;
  logic [PLW-1:0]       pl_next;
  logic                 accept, rsp_gen, pop;
  logic [CW-1:0]        credit;
  logic                 vld_p0, vld_p1;
  logic [PLW-1:0]       pl_p0, pl_p1;
  logic                 fin_vld;
  logic [PLW-1:0]       fin_pl;
  logic [PLW-1:0]       fifo_mem [F];
  logic [PTW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 out_vld;
  logic [PLW-1:0]       out_pl;
  logic                 out_free, take_fifo, take_pipe, push;
  logic [CW:0]          occ;

  assign accept        = bus.req_valid && bus.req_ready;
  assign rsp_gen       = !bus.req_we || bus.req_rsp;
  assign bus.req_ready = (credit < F_C);

  // Returned word for a write depends on mode: stored word (read-first) or merged word.
  assign cur_word = mem[bus.req_addr];
  assign wr_word  = merge_word(cur_word, bus.req_data, bus.req_be);
  assign ret_word = (WRITE_FIRST && bus.req_we) ? wr_word : cur_word;

`ifdef BRAM_SP_STREAM_PARITY_EN
  logic [NB_COL-1:0] par_mem [RAM_DEPTH];
  logic [NB_COL-1:0] cur_par, wr_par, ret_par;

  // Stored parity is inverted per enabled column when an error is injected.
  assign cur_par = par_mem[bus.req_addr];
  assign wr_par  = col_parity(bus.req_data) ^ {NB_COL{bus.perr_inject}};
  assign ret_par = (WRITE_FIRST && bus.req_we) ? ((cur_par & ~bus.req_be) | (wr_par & bus.req_be))
                                               : cur_par;
  assign pl_next = {col_parity(ret_word) ^ ret_par, ret_word};

  always @(posedge clka) begin
    if (accept && bus.req_we)
      for (int c = 0; c < NB_COL; c++)
        if (bus.req_be[c]) par_mem[bus.req_addr][c] <= wr_par[c];
  end
`else
  assign pl_next = ret_word;
`endif

  initial begin
    for (int i = 0; i < RAM_DEPTH; i++) begin
      mem[i] <= '0;
`ifdef BRAM_SP_STREAM_PARITY_EN
      par_mem[i] <= '0;
`endif
    end
  end

  always @(posedge clka) begin
    if (accept && bus.req_we)
      for (int c = 0; c < NB_COL; c++)
        if (bus.req_be[c])
          mem[bus.req_addr][c*COL_WIDTH +: COL_WIDTH] <= bus.req_data[c*COL_WIDTH +: COL_WIDTH];
  end

  // Stage p0: RAM read; stage p1: optional RAM output register
  always_ff @(posedge clka) begin
    if (accept) pl_p0 <= pl_next;
    pl_p1 <= pl_p0;
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= accept && rsp_gen;
      vld_p1 <= vld_p0;
    end
  end

  assign fin_vld = (LATENCY == 1) ? vld_p0 : vld_p1;
  assign fin_pl  = (LATENCY == 1) ? pl_p0  : pl_p1;

  // Stage fifo: the output register is refilled from storage first, else straight from the RAM
  assign out_free  = !out_vld || bus.rsp_ready;
  assign pop       = out_vld && bus.rsp_ready;
  assign take_fifo = out_free && (count != '0);
  assign take_pipe = out_free && (count == '0) && fin_vld;
  assign push      = fin_vld && !take_pipe;

  always_ff @(posedge clka) begin
    if (push) fifo_mem[wr_ptr] <= fin_pl;
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      out_vld <= 1'b0;
      out_pl  <= '0;
      credit  <= '0;
    end else begin
      if (push)      wr_ptr <= ptr_inc(wr_ptr);
      if (take_fifo) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !take_fifo)      count <= count + 1'b1;
      else if (!push && take_fifo) count <= count - 1'b1;
      if (take_fifo) begin
        out_vld <= 1'b1;
        out_pl  <= fifo_mem[rd_ptr];
      end else if (take_pipe) begin
        out_vld <= 1'b1;
        out_pl  <= fin_pl;
      end else if (pop) begin
        out_vld <= 1'b0;
      end
      if (accept && rsp_gen && !pop)      credit <= credit + 1'b1;
      else if (pop && !(accept && rsp_gen)) credit <= credit - 1'b1;
    end
  end

  assign bus.rsp_valid = out_vld;
  assign bus.rsp_data  = out_pl[RAM_WIDTH-1:0];
`ifdef BRAM_SP_STREAM_PARITY_EN
  assign bus.rsp_perr  = out_pl[PLW-1 -: NB_COL];
`endif

  assign occ = {1'b0, count} + {{CW{1'b0}}, out_vld};

  occupancy_bound: assert property (@(posedge clka) disable iff (rsta) occ <= {1'b0, F_C});
  credit_bound:    assert property (@(posedge clka) disable iff (rsta) credit <= F_C);
endmodule

// File: tb/tb_bram_sp_stream.sv
// Randomized self-checking bench for bram_sp_stream against a word-level memory model
// and an in-order expected-response queue.
module tb_bram_sp_stream;
  localparam int    NB_COL     = 4;
  localparam int    COL_WIDTH  = 8;
  localparam int    RAM_DEPTH  = 1024;
  localparam int    LATENCY    = 2;
  localparam string WRITE_MODE = "READ_FIRST";

  typedef struct {
    logic [31:0] data;
    logic [3:0]  perr;
  } exp_t;

  logic clka = 1'b0;
  logic rsta;
  always #5 clka = ~clka;

  bram_sp_stream_if #(.NB_COL(NB_COL), .COL_WIDTH(COL_WIDTH), .RAM_DEPTH(RAM_DEPTH)) bus ();

  bram_sp_stream #(
    .NB_COL(NB_COL), .COL_WIDTH(COL_WIDTH), .RAM_DEPTH(RAM_DEPTH),
    .LATENCY(LATENCY), .WRITE_MODE(WRITE_MODE), .INIT_FILE("")
  ) dut (
    .clka(clka),
    .rsta(rsta),
    .bus(bus)
  );

  logic [31:0] ref_mem [RAM_DEPTH];
  logic [3:0]  ref_par [RAM_DEPTH];
  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          pops   = 0;
  logic [31:0] last_rsp;
  logic [3:0]  last_perr;
  logic [31:0] held_data;
  bit          hold_pending;
  bit          acc_flag;
  logic        cur_inj;

  function automatic logic [3:0] word_parity(input logic [31:0] w);
    logic [3:0] p;
    for (int c = 0; c < 4; c++) p[c] = ^w[c*8 +: 8];
    return p;
  endfunction

  task automatic model_accept();
    logic [31:0] old_w, new_w;
    logic [3:0]  old_p, new_p;
    exp_t        e;
    old_w = ref_mem[bus.req_addr];
    old_p = ref_par[bus.req_addr];
    new_w = old_w;
    new_p = old_p;
    for (int c = 0; c < 4; c++)
      if (bus.req_be[c]) begin
        new_w[c*8 +: 8] = bus.req_data[c*8 +: 8];
        new_p[c]        = (^bus.req_data[c*8 +: 8]) ^ cur_inj;
      end
    if (!bus.req_we) begin
      e.data = old_w; e.perr = word_parity(old_w) ^ old_p;
      exp_q.push_back(e);
    end else begin
      if (bus.req_rsp) begin
        if (WRITE_MODE == "WRITE_FIRST") begin e.data = new_w; e.perr = word_parity(new_w) ^ new_p; end
        else begin e.data = old_w; e.perr = word_parity(old_w) ^ old_p; end
        exp_q.push_back(e);
      end
      ref_mem[bus.req_addr] = new_w;
      ref_par[bus.req_addr] = new_p;
    end
  endtask

  // Samples at negedge+1, scores any pop and accept happening at the coming edge, then advances.
  task automatic cycle();
    exp_t e;
    acc_flag = 1'b0;
    if (rsta) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== held_data) begin
          errors++;
          $display("FAIL hold: valid=%b data=%h required valid=1 data=%h", bus.rsp_valid, bus.rsp_data, held_data);
        end
      end
      hold_pending = bus.rsp_valid && !bus.rsp_ready;
      held_data    = bus.rsp_data;
      if (bus.rsp_valid && bus.rsp_ready) begin
        checks++;
        pops++;
        last_rsp = bus.rsp_data;
`ifdef BRAM_SP_STREAM_PARITY_EN
        last_perr = bus.rsp_perr;
`endif
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: data=%h required no response", bus.rsp_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.rsp_data !== e.data) begin
            errors++;
            $display("FAIL rsp_data: got %h required %h", bus.rsp_data, e.data);
          end
`ifdef BRAM_SP_STREAM_PARITY_EN
          if (bus.rsp_perr !== e.perr) begin
            errors++;
            $display("FAIL rsp_perr: got %b required %b", bus.rsp_perr, e.perr);
          end
`endif
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        acc_flag = 1'b1;
        model_accept();
      end
    end
    @(posedge clka);
    @(negedge clka);
    #1;
  endtask

  task automatic do_op(input logic we, input logic [9:0] addr, input logic [3:0] be,
                       input logic [31:0] data, input logic rsp, input logic inj);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
    bus.req_be = be; bus.req_data = data; bus.req_rsp = rsp; cur_inj = inj;
`ifdef BRAM_SP_STREAM_PARITY_EN
    bus.perr_inject = inj;
`endif
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (acc_flag) break;
    end
    if (!acc_flag) begin
      checks++; errors++;
      $display("FAIL accept_timeout: addr=%h not accepted within 20 cycles", addr);
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && bus.rsp_valid === 1'b0) break;
      cycle();
    end
    checks++;
    if (exp_q.size() != 0 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: pending=%0d rsp_valid=%b required 0 and 0", exp_q.size(), bus.rsp_valid);
    end
  endtask

  task automatic test_reset();
    rsta = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_be = '0;
    bus.req_data = '0; bus.req_rsp = 1'b0; bus.rsp_ready = 1'b1; cur_inj = 1'b0;
`ifdef BRAM_SP_STREAM_PARITY_EN
    bus.perr_inject = 1'b0;
`endif
    @(negedge clka); #1;
    cycle(); cycle();
    rsta = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b required 1", bus.req_ready); end
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b required 0", bus.rsp_valid); end
    checks++;
    if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h required 0", bus.rsp_data); end
`ifdef BRAM_SP_STREAM_PARITY_EN
    checks++;
    if (bus.rsp_perr !== 4'h0) begin errors++; $display("FAIL reset_rsp_perr: got %b required 0", bus.rsp_perr); end
`endif
  endtask

  task automatic test_latency();
    do_op(1'b1, 10'd5, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0);
    do_op(1'b0, 10'd5, 4'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL latency_edge1: rsp_valid=%b required 0", bus.rsp_valid); end
    cycle();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL latency_edge2: rsp_valid=%b required 0", bus.rsp_valid); end
    cycle();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL latency_edge3: valid=%b data=%h required 1 deadbeef", bus.rsp_valid, bus.rsp_data);
    end
    drain();
  endtask

  task automatic test_byte_enable();
    do_op(1'b1, 10'd7, 4'hF, 32'h11223344, 1'b0, 1'b0);
    do_op(1'b1, 10'd7, 4'b0101, 32'hAABBCCDD, 1'b0, 1'b0);
    do_op(1'b0, 10'd7, 4'h0, 32'h0, 1'b0, 1'b0);
    drain();
    checks++;
    if (last_rsp !== 32'h11BB33DD) begin errors++; $display("FAIL byte_enable: got %h required 11bb33dd", last_rsp); end
  endtask

  task automatic test_backpressure();
    int accepted, p0;
    for (int i = 0; i < 5; i++) do_op(1'b1, 10'(20 + i), 4'hF, $urandom, 1'b0, 1'b0);
    bus.rsp_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 10'(20 + accepted);
      cycle();
      if (acc_flag) accepted++;
    end
    bus.req_valid = 1'b0;
    checks++;
    if (accepted != 3) begin errors++; $display("FAIL bp_accepts: got %0d required 3", accepted); end
    checks++;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b required 0", bus.req_ready); end
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== ref_mem[20]) begin
      errors++;
      $display("FAIL bp_head: valid=%b data=%h required 1 %h", bus.rsp_valid, bus.rsp_data, ref_mem[20]);
    end
    p0 = pops;
    bus.rsp_ready = 1'b1;
    cycle();
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b required 1", bus.req_ready); end
    drain();
    checks++;
    if (pops - p0 != 3) begin errors++; $display("FAIL bp_pops: got %0d required 3", pops - p0); end
  endtask

  task automatic test_write_mode();
    int p0, seen;
    logic [31:0] want;
    want = (WRITE_MODE == "WRITE_FIRST") ? 32'h2 : 32'h1;
    do_op(1'b1, 10'd9, 4'hF, 32'h1, 1'b0, 1'b0);
    do_op(1'b1, 10'd9, 4'hF, 32'h2, 1'b1, 1'b0);
    drain();
    checks++;
    if (last_rsp !== want) begin errors++; $display("FAIL write_rsp: got %h required %h", last_rsp, want); end
    p0 = pops; seen = 0;
    do_op(1'b1, 10'd9, 4'hF, 32'h3, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (bus.rsp_valid === 1'b1) seen++;
      cycle();
    end
    checks++;
    if (seen != 0 || pops != p0) begin errors++; $display("FAIL write_no_rsp: valid_cycles=%0d required 0", seen); end
    do_op(1'b0, 10'd9, 4'h0, 32'h0, 1'b0, 1'b0);
    drain();
    checks++;
    if (last_rsp !== 32'h3) begin errors++; $display("FAIL write_no_rsp_data: got %h required 3", last_rsp); end
  endtask

  task automatic test_reset_mid();
    int seen;
    bus.rsp_ready = 1'b1;
    do_op(1'b0, 10'd5, 4'h0, 32'h0, 1'b0, 1'b0);
    do_op(1'b0, 10'd7, 4'h0, 32'h0, 1'b0, 1'b0);
    rsta = 1'b1;
    cycle();
    rsta = 1'b0;
    exp_q.delete();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.rsp_valid !== 1'b0) seen++;
      cycle();
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL reset_mid_valid: valid_cycles=%0d required 0", seen); end
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready: got %b required 1", bus.req_ready); end
    do_op(1'b0, 10'd5, 4'h0, 32'h0, 1'b0, 1'b0);
    drain();
    checks++;
    if (last_rsp !== 32'hDEADBEEF) begin errors++; $display("FAIL reset_mid_mem: got %h required deadbeef", last_rsp); end
  endtask

  task automatic test_back_to_back();
    do_op(1'b1, 10'd30, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0);
    do_op(1'b0, 10'd30, 4'h0, 32'h0, 1'b0, 1'b0);
    drain();
    checks++;
    if (last_rsp !== 32'hCAFEF00D) begin errors++; $display("FAIL raw_hazard: got %h required cafef00d", last_rsp); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.rsp_ready = ($urandom_range(3) != 0);
      bus.req_valid = ($urandom_range(9) < 7);
      bus.req_we    = $urandom_range(1);
      bus.req_addr  = 10'($urandom_range(15));
      bus.req_be    = 4'($urandom);
      bus.req_data  = $urandom;
      bus.req_rsp   = $urandom_range(1);
      cur_inj       = ($urandom_range(7) == 0);
`ifdef BRAM_SP_STREAM_PARITY_EN
      bus.perr_inject = cur_inj;
`endif
      cycle();
    end
    cur_inj = 1'b0;
`ifdef BRAM_SP_STREAM_PARITY_EN
    bus.perr_inject = 1'b0;
`endif
    drain();
  endtask

`ifdef BRAM_SP_STREAM_PARITY_EN
  task automatic test_parity();
    do_op(1'b1, 10'd40, 4'b0001, 32'hFF00FF00, 1'b0, 1'b1);
    do_op(1'b0, 10'd40, 4'h0, 32'h0, 1'b0, 1'b0);
    drain();
    checks++;
    if (last_perr !== 4'b0001) begin errors++; $display("FAIL parity_inject: got %b required 0001", last_perr); end
    do_op(1'b1, 10'd40, 4'hF, 32'hFF00FF00, 1'b0, 1'b0);
    do_op(1'b0, 10'd40, 4'h0, 32'h0, 1'b0, 1'b0);
    drain();
    checks++;
    if (last_perr !== 4'b0000) begin errors++; $display("FAIL parity_clean: got %b required 0000", last_perr); end
  endtask
`endif

  initial begin
    for (int i = 0; i < RAM_DEPTH; i++) begin
      ref_mem[i] = '0;
      ref_par[i] = '0;
    end
    hold_pending = 1'b0;
    last_rsp  = '0;
    last_perr = '0;
    held_data = '0;
    test_reset();
    test_latency();
    test_byte_enable();
    test_backpressure();
    test_write_mode();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef BRAM_SP_STREAM_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
